fmap_pixel_assembler: RTL and testbench

Streams a feature map into the array-parallel tensor form consumed by the pointwise and depthwise convolution stages. It accepts one pixel per handshake, carrying all channels, in raster order and writes it into a registered `[H][W][C]` tensor. When the frame is complete it pulses `frame_valid`, which drives the downstream stage's `valid_in`, and holds the tensor stable for a programmable guard window. It sits between the DMA/line-buffer front end and the first convolution layer.

---
 rtl/fmap_pixel_assembler.sv | 150 +++++++++++++++
 tb/tb_fmap_pixel_assembler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_pixel_assembler.sv
// Raster pixel stream to registered [H][W][C] tensor with frame_valid pulse and hold window.
// Optional FMAP_PIXEL_ASSEMBLER_LAST_CHECK_EN enables pix_last framing checks and err_last.
module fmap_pixel_assembler #(
  parameter int IN_CHANNELS = 1,
  parameter int IN_HEIGHT   = 112,
  parameter int IN_WIDTH    = 112,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] pix_in [0:IN_CHANNELS-1],
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic                         pix_last,
  output logic signed [DATA_WIDTH-1:0] frame_out [0:IN_HEIGHT-1][0:IN_WIDTH-1][0:IN_CHANNELS-1],
  output logic                         frame_valid,
  output logic                         frame_busy,
  input  logic                         err_clr,
  output logic                         err_last
);

  localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [7:0]    HOLD_LD  = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    hold_cnt;
  logic          accept;
  logic          at_end;
  logic          resync;

  assign accept = pix_valid && pix_ready;
  assign at_end = (row == ROW_LAST) && (col == COL_LAST);

`ifdef FMAP_PIXEL_ASSEMBLER_LAST_CHECK_EN
  logic err_set;

  // Early last resynchronises; a missing last only flags.
  assign resync  = accept && pix_last && !at_end;
  assign err_set = accept && (pix_last != at_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_last <= 1'b0;
    end else if (err_set) begin
      err_last <= 1'b1;
    end else if (err_clr) begin
      err_last <= 1'b0;
    end
  end
`else
  logic unused_in;

  assign resync    = 1'b0;
  assign err_last  = 1'b0;
  assign unused_in = ^{pix_last, err_clr};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pix_ready   = 1'b0;
    frame_valid = 1'b0;
    frame_busy  = 1'b0;
    unique case (state)
      FILL: begin
        pix_ready = 1'b1;
        if (accept && at_end) begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        frame_valid = 1'b1;
        frame_busy  = 1'b1;
        state_nx    = (HOLD_CYCLES > 0) ? HOLD : FILL;
      end
      HOLD: begin
        frame_busy = 1'b1;
        if (hold_cnt <= 8'd1) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (at_end || resync) begin
        row <= '0;
        col <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == EMIT) begin
      hold_cnt <= HOLD_LD;
    end else if (state == HOLD) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  // accept implies FILL, so the tensor is frozen in EMIT/HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < IN_HEIGHT; r++) begin
        for (int c = 0; c < IN_WIDTH; c++) begin
          for (int k = 0; k < IN_CHANNELS; k++) begin
            frame_out[r][c][k] <= '0;
          end
        end
      end
    end else if (accept) begin
      for (int k = 0; k < IN_CHANNELS; k++) begin
        frame_out[row][col][k] <= pix_in[k];
      end
    end
  end

endmodule

// File: tb/tb_fmap_pixel_assembler.sv
// Directed bench for fmap_pixel_assembler, H=W=C=2, with HOLD_CYCLES 2 and 0 instances.
module tb_fmap_pixel_assembler;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] pix_in [0:1];
  logic              pix_valid = 1'b0;
  logic              pix_valid0 = 1'b0;
  logic              pix_last = 1'b0;
  logic              err_clr = 1'b0;
  logic              rdy, fv, busy, err;
  logic              rdy0, fv0, busy0, err0;
  logic signed [7:0] fo  [0:1][0:1][0:1];
  logic signed [7:0] fo0 [0:1][0:1][0:1];

  int nvec = 0;
  int nerr = 0;
  int fv_cnt = 0;

  always #5 clk = ~clk;

  fmap_pixel_assembler #(
    .IN_CHANNELS(2), .IN_HEIGHT(2), .IN_WIDTH(2),
    .DATA_WIDTH(8), .HOLD_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(rdy), .pix_last(pix_last),
    .frame_out(fo), .frame_valid(fv), .frame_busy(busy),
    .err_clr(err_clr), .err_last(err)
  );

  fmap_pixel_assembler #(
    .IN_CHANNELS(2), .IN_HEIGHT(2), .IN_WIDTH(2),
    .DATA_WIDTH(8), .HOLD_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .pix_in(pix_in),
    .pix_valid(pix_valid0), .pix_ready(rdy0), .pix_last(pix_last),
    .frame_out(fo0), .frame_valid(fv0), .frame_busy(busy0),
    .err_clr(err_clr), .err_last(err0)
  );

  always @(posedge clk) if (fv) fv_cnt++;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_px(input string tag, input int r, input int c,
                        input int a, input int b);
    chk(tag, fo[r][c][0], a);
    chk(tag, fo[r][c][1], b);
  endtask

  task automatic send(input int a, input int b, input logic last);
    int n;
    pix_in[0] = 8'(a);
    pix_in[1] = 8'(b);
    pix_last = last;
    pix_valid = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    chk("send_timeout", n < 20, 1);
    tick();
    pix_last = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    pix_valid = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    chk("ready_timeout", n < 20, 1);
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    pix_valid0 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt, snap, lows, p0;
    pix_in[0] = '0;
    pix_in[1] = '0;
    #2;
    chk("rst_fv", fv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_fo11", fo[1][1][1], 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", rdy, 1);

    // back-to-back frame
    send(1, -1, 0);
    send(2, -2, 0);
    send(3, -3, 0);
    send(4, -4, 1);
    chk("b2b_fv", fv, 1);
    pix_valid = 1'b0;
    chk_px("b2b_px11", 1, 1, 4, -4);
    chk_px("b2b_px01", 0, 1, 2, -2);
    chk_px("b2b_px00", 0, 0, 1, -1);
    chk_px("b2b_px10", 1, 0, 3, -3);
    cnt = 0;
    while (!rdy && cnt < 10) begin
      chk("b2b_busy", busy, 1);
      tick();
      cnt++;
    end
    chk("b2b_ready_low", cnt, 3);
    chk("b2b_fv_done", fv, 0);

    // gapped input on a cleared tensor
    do_reset();
    chk("gap_clear", fo[1][1][0], 0);
    for (int i = 1; i <= 4; i++) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      send(i, -i, i == 4);
      if (i < 4) chk("gap_nofv", fv, 0);
    end
    chk("gap_fv", fv, 1);
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk_px("gap_px", i / 2, i % 2, i + 1, -(i + 1));
    wait_ready();

    // stall during HOLD
    send(10, -10, 0);
    send(11, -11, 0);
    send(12, -12, 0);
    send(13, -13, 1);
    chk("stall_fv", fv, 1);
    pix_in[0] = 8'sd7;
    pix_in[1] = 8'sd7;
    pix_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_rdy", rdy, 0);
      chk_px("stall_hold00", 0, 0, 10, -10);
      chk_px("stall_hold11", 1, 1, 13, -13);
    end
    tick();
    chk("stall_rdy_back", rdy, 1);
    chk_px("stall_pre", 0, 0, 10, -10);
    tick();
    chk_px("stall_land", 0, 0, 7, 7);
    chk_px("stall_keep", 0, 1, 11, -11);
    send(8, 8, 0);
    send(9, 9, 0);
    send(10, 10, 1);
    chk("stall_fv2", fv, 1);
    wait_ready();

    // pix_last framing
    snap = fv_cnt;
    send(1, 1, 0);
    send(2, 2, 1);
    chk("last_nofv", fv, 0);
`ifdef FMAP_PIXEL_ASSEMBLER_LAST_CHECK_EN
    chk("last_err", err, 1);
    pix_valid = 1'b0;
    tick();
    tick();
    chk("last_drop", fv_cnt, snap);
    send(21, -21, 0);
    send(22, -22, 0);
    send(23, -23, 0);
    send(24, -24, 1);
    chk("last_fv", fv, 1);
    chk_px("last_px00", 0, 0, 21, -21);
    chk("last_err_hold", err, 1);
`else
    chk("last_err_tied", err, 0);
    send(3, 3, 0);
    send(4, 4, 1);
    chk("last_fv", fv, 1);
    chk_px("last_px01", 0, 1, 2, 2);
`endif
    wait_ready();
    chk("last_one_fv", fv_cnt, snap + 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("last_err_clr", err, 0);

    // reset mid-frame
    send(31, -31, 0);
    send(32, -32, 0);
    send(33, -33, 0);
    pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) chk("mid_zero", fo[i / 4][(i / 2) % 2][i % 2], 0);
    chk("mid_fv", fv, 0);
    chk("mid_busy", busy, 0);
    snap = fv_cnt;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("mid_nofv", fv_cnt, snap);
    send(41, 1, 0);
    send(42, 2, 0);
    send(43, 3, 0);
    send(44, 4, 1);
    chk("mid_fv_new", fv, 1);
    chk_px("mid_px11", 1, 1, 44, 4);
    wait_ready();
    chk("mid_one_fv", fv_cnt, snap + 1);

    // HOLD_CYCLES = 0, continuous stream
    do_reset();
    pix_valid0 = 1'b1;
    lows = 0;
    p0 = 0;
    for (int i = 0; i < 10; i++) begin
      pix_in[0] = 8'(i);
      pix_in[1] = 8'(-i);
      if (!rdy0) lows++;
      if (fv0) p0++;
      if (!rdy0) chk("h0_fv_on_low", fv0, 1);
      tick();
    end
    pix_valid0 = 1'b0;
    chk("h0_ready_low", lows, 2);
    chk("h0_frames", p0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
